// File: rtl/vproc_xreg_result_queue.sv
// In-order FIFO for scalar (x-register) vector results ahead of the XIF result arbiter.
// Optional same-cycle bypass when empty: define VPROC_XREG_RESULT_BYPASS_EN.
module vproc_xreg_result_queue #(
  parameter int unsigned XIF_ID_W       = 3,
  parameter int unsigned DEPTH          = 4,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       async_rst_ni,
  input  logic                       sync_rst_ni,

  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [XIF_ID_W-1:0]        enq_id_i,
  input  logic [4:0]                 enq_addr_i,
  input  logic [31:0]                enq_data_i,

  output logic                       result_xreg_valid_o,
  input  logic                       result_xreg_ready_i,
  output logic [XIF_ID_W-1:0]        result_xreg_id_o,
  output logic [4:0]                 result_xreg_addr_o,
  output logic [31:0]                result_xreg_data_o,

  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. Valid never drops and the payload never changes until that transfer;
  // ready may toggle freely and enq_ready_o depends on queue state only.

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                full, empty;
  logic                push, pop, bypass;
  logic                out_valid;

  logic [XIF_ID_W-1:0] id_q   [DEPTH];
  logic [4:0]          addr_q [DEPTH];
  logic [31:0]         data_q [DEPTH];

  // MSB of each pointer is a wrap bit distinguishing full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

  always_comb begin
    bypass = 1'b0;
`ifdef VPROC_XREG_RESULT_BYPASS_EN
    bypass = empty & enq_valid_i;
`endif
    // A bypassed result consumed in its arrival cycle is never stored
    push = enq_valid_i & ~full & ~(bypass & result_xreg_ready_i);
    pop  = ~empty & result_xreg_ready_i;
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (!sync_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Payload storage carries no reset; only the pointers define occupancy
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q  [wr_ptr_q[IW-1:0]] <= enq_id_i;
      addr_q[wr_ptr_q[IW-1:0]] <= enq_addr_i;
      data_q[wr_ptr_q[IW-1:0]] <= enq_data_i;
    end
  end

  always_comb begin
    out_valid          = ~empty;
    result_xreg_id_o   = id_q  [rd_ptr_q[IW-1:0]];
    result_xreg_addr_o = addr_q[rd_ptr_q[IW-1:0]];
    result_xreg_data_o = data_q[rd_ptr_q[IW-1:0]];
    if (bypass) begin
      out_valid          = 1'b1;
      result_xreg_id_o   = enq_id_i;
      result_xreg_addr_o = enq_addr_i;
      result_xreg_data_o = enq_data_i;
    end
    if (!out_valid) begin
      result_xreg_id_o   = DONT_CARE_ZERO ? '0 : 'x;
      result_xreg_addr_o = DONT_CARE_ZERO ? '0 : 'x;
      result_xreg_data_o = DONT_CARE_ZERO ? '0 : 'x;
    end
  end

  assign result_xreg_valid_o = out_valid;
  assign enq_ready_o         = ~full;
  assign count_o             = wr_ptr_q - rd_ptr_q;
  assign empty_o             = empty;

endmodule

// File: tb/tb_vproc_xreg_result_queue.sv
// Randomized scoreboard bench for vproc_xreg_result_queue; the expected queue is the FIFO model.
module tb_vproc_xreg_result_queue;

  localparam int unsigned XIF_ID_W = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned EW       = XIF_ID_W + 5 + 32;

  logic                  clk = 1'b0;
  logic                  async_rst_ni = 1'b0;
  logic                  sync_rst_ni  = 1'b1;
  logic                  enq_valid_i  = 1'b0;
  logic                  enq_ready_o;
  logic [XIF_ID_W-1:0]   enq_id_i     = '0;
  logic [4:0]            enq_addr_i   = '0;
  logic [31:0]           enq_data_i   = '0;
  logic                  result_xreg_valid_o;
  logic                  result_xreg_ready_i = 1'b0;
  logic [XIF_ID_W-1:0]   result_xreg_id_o;
  logic [4:0]            result_xreg_addr_o;
  logic [31:0]           result_xreg_data_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                  empty_o;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  vproc_xreg_result_queue #(
    .XIF_ID_W       (XIF_ID_W),
    .DEPTH          (DEPTH),
    .DONT_CARE_ZERO (1'b1)
  ) dut (
    .clk_i               (clk),
    .async_rst_ni        (async_rst_ni),
    .sync_rst_ni         (sync_rst_ni),
    .enq_valid_i         (enq_valid_i),
    .enq_ready_o         (enq_ready_o),
    .enq_id_i            (enq_id_i),
    .enq_addr_i          (enq_addr_i),
    .enq_data_i          (enq_data_i),
    .result_xreg_valid_o (result_xreg_valid_o),
    .result_xreg_ready_i (result_xreg_ready_i),
    .result_xreg_id_o    (result_xreg_id_o),
    .result_xreg_addr_o  (result_xreg_addr_o),
    .result_xreg_data_o  (result_xreg_data_o),
    .count_o             (count_o),
    .empty_o             (empty_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / monitor: checks at negedge, then advances the model for the coming edge
  always @(negedge clk) begin
    int sz;
    logic exp_valid;
    logic [EW-1:0] head;
    if (!async_rst_ni) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      exp_valid = (sz > 0);
`ifdef VPROC_XREG_RESULT_BYPASS_EN
      if (sz == 0 && enq_valid_i) exp_valid = 1'b1;
`endif
      check("count", 64'(count_o), 64'(sz));
      check("empty", 64'(empty_o), 64'(sz == 0));
      check("enq_ready", 64'(enq_ready_o), 64'(sz < DEPTH));
      check("valid", 64'(result_xreg_valid_o), 64'(exp_valid));
      if (!sync_rst_ni) begin
        exp_q.delete();
      end else begin
        if (enq_valid_i && sz < DEPTH)
          exp_q.push_back({enq_id_i, enq_addr_i, enq_data_i});
        if (result_xreg_valid_o && exp_q.size() > 0) begin
          head = exp_q[0];
          check("head_id",   64'(result_xreg_id_o),   64'(head[EW-1 -: XIF_ID_W]));
          check("head_addr", 64'(result_xreg_addr_o), 64'(head[36:32]));
          check("head_data", 64'(result_xreg_data_o), 64'(head[31:0]));
          if (result_xreg_ready_i) void'(exp_q.pop_front());
        end else if (!result_xreg_valid_o) begin
          check("idle_zero", 64'({result_xreg_id_o, result_xreg_addr_o, result_xreg_data_o}), 64'(0));
        end
      end
    end
  end

  // driver: one cycle of traffic; payload held until accepted, then advanced
  task automatic step(input bit v, input bit r);
    bit acc;
    enq_valid_i = v;
    result_xreg_ready_i = r;
    @(negedge clk);
    acc = v && enq_ready_o;
    @(posedge clk);
    #1;
    if (acc) begin
      enq_id_i   = enq_id_i + 1'b1;
      enq_addr_i = 5'($urandom_range(0, 31));
      enq_data_i = $urandom;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 async_rst_ni = 1'b1;
    step(0, 0);
    check("rst_valid", 64'(result_xreg_valid_o), 64'(0));
    check("rst_ready", 64'(enq_ready_o), 64'(1));

    // single result
    enq_id_i = 3; enq_addr_i = 10; enq_data_i = 32'hDEADBEEF;
    step(1, 1);
    step(0, 1);
    step(0, 1);

    // fill, then a refused fifth offer
    enq_id_i = 0;
    repeat (4) step(1, 0);
    step(1, 0);
    check("full_count", 64'(count_o), 64'(DEPTH));
    check("full_ready", 64'(enq_ready_o), 64'(0));
    check("full_head", 64'(result_xreg_id_o), 64'(0));

    // streaming from full
    repeat (8) step(1, 1);
    repeat (6) step(0, 1);

    // two entries, simultaneous traffic across pointer wrap
    repeat (2) step(1, 0);
    repeat (10) step(1, 1);
    check("wrap_count", 64'(count_o), 64'(2));
    repeat (3) step(0, 1);

    // sync flush with three entries held
    repeat (3) step(1, 0);
    sync_rst_ni = 1'b0;
    step(0, 0);
    sync_rst_ni = 1'b1;
    check("flush_valid", 64'(result_xreg_valid_o), 64'(0));
    check("flush_count", 64'(count_o), 64'(0));
    enq_id_i = 5;
    step(1, 0);
    check("flush_head", 64'(result_xreg_id_o), 64'(5));
    step(0, 1);

    // async reset mid-transfer
    repeat (2) step(1, 0);
    #2 async_rst_ni = 1'b0;
    #1;
    check("arst_valid", 64'(result_xreg_valid_o), 64'(0));
    check("arst_count", 64'(count_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 async_rst_ni = 1'b1;
    step(0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50);

    // drain
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(0, 1);
    check("drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vproc_xreg_result_queue.md
Name: vproc_xreg_result_queue

Overview:
- FIFO that buffers scalar (x-register) write-back results from the vector pipelines, such as vmv.x.s, vcpop.m and vfirst.m.
- Feeds the XREG input of the coprocessor result arbiter via a valid/ready handshake. Results leave in arrival order.
- Decouples pipeline completion from XIF result back-pressure, so a stalled host does not stall the pipelines until the queue fills.

Parameters:
- XIF_ID_W, 3, width in bits of XIF instruction IDs.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- DONT_CARE_ZERO, 1'b0, drive don't-care outputs to zero instead of X.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- async_rst_ni  in  1  reset: asynchronous, active-low.
- sync_rst_ni  in  1  synchronous active-low flush; same effect as async reset, applied at the clock edge.
- enq_valid_i  in  1  pipeline offers a result.
- enq_ready_o  out  1  queue accepts a result.
- enq_id_i  in  XIF_ID_W  instruction ID of the offered result.
- enq_addr_i  in  5  destination x-register index.
- enq_data_i  in  32  result value.
- result_xreg_valid_o  out  1  head entry valid toward the result arbiter.
- result_xreg_ready_i  in  1  arbiter consumes the head entry.
- result_xreg_id_o  out  XIF_ID_W  head entry instruction ID.
- result_xreg_addr_o  out  5  head entry register index.
- result_xreg_data_o  out  32  head entry data.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.
- empty_o  out  1  high when count_o == 0.

Behaviour:
- Storage and pointers
  - Circular buffer of DEPTH entries {id, addr, data}.
  - Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - Full: pointers are equal except the MSB. Empty: pointers are fully equal.
  - Pointers wrap modulo 2*DEPTH with no special case.
  - Only pointers/count carry reset; data storage is not reset.
- Reset (async, or sync_rst_ni low at an edge)
  - Both pointers go to 0, count_o = 0, empty_o = 1.
  - result_xreg_valid_o = 0, and enq_ready_o = 1 once reset is released.
  - Reset mid-operation discards all buffered entries; none is presented afterwards.
- Enqueue
  - enq_ready_o = ~full. It is purely state-derived and never depends combinationally on result_xreg_ready_i.
  - Fire on enq_valid_i & enq_ready_o: write to the entry at the write pointer, then increment the write pointer.
  - Without the optional feature, an accepted entry becomes visible on result_xreg_* one cycle after acceptance.
- Dequeue
  - result_xreg_valid_o = ~empty.
  - Outputs show the head entry. When invalid, id/addr/data are 0 if DONT_CARE_ZERO, otherwise X.
  - Fire on result_xreg_valid_o & result_xreg_ready_i: increment the read pointer.
  - The head must stay stable while valid and not ready. The downstream may withdraw ready, but the queue never withdraws valid.
- Simultaneous events
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - When full, an enqueue is refused even if a dequeue fires that cycle; enq_ready_o is already 0.
  - When empty, a dequeue is impossible.
- Count
  - count_o = wr_ptr - rd_ptr, taken modulo 2*DEPTH.
  - Range 0..DEPTH, updated one cycle after each fire.
- Ordering: strict FIFO; IDs are not reordered or inspected.

Optional Feature:
- Macro: VPROC_XREG_RESULT_BYPASS_EN.
- Enabled, queue empty and enq_valid_i high:
  - result_xreg_* presents the enq_* inputs combinationally, with result_xreg_valid_o = 1 in the same cycle.
  - If result_xreg_ready_i is also high, the result is consumed without being written and the pointers are unchanged.
  - Otherwise it is written normally and shown from storage in later cycles with identical values.
  - Zero-cycle latency when empty.
- Disabled: no combinational path from enq_* to result_xreg_*; minimum latency is one cycle.

Test Plan:
- Reset, then a single enqueue {id=3, addr=10, data=0xDEADBEEF} with ready=1.
  - Disabled: valid at cycle+1 with those values; count_o goes 1 then 0.
  - Enabled: valid in the same cycle; count_o stays 0.
- Fill with DEPTH=4 entries (ids 0..3) with result_xreg_ready_i=0.
  - Required: enq_ready_o=0, count_o=4, head id=0 stable.
  - A 5th enq_valid_i is not accepted.
- From full, hold ready=1 and enq_valid_i=1 for 8 cycles with rising ids.
  - Required: outputs ids in order with no loss or duplicates.
  - Count oscillates within 3..4 and enq_ready_o tracks ~full.
- Simultaneous enqueue/dequeue with 2 entries for 10 cycles, crossing pointer wrap.
  - Required: count_o stays 2 and data matches in FIFO order across the wrap.
- Hold 3 entries, pulse sync_rst_ni low for one cycle.
  - Required: next cycle valid=0, count_o=0, enq_ready_o=1.
  - A subsequent enqueue (id=5) emerges as the head, not a stale entry.
- Assert async_rst_ni low mid-transfer while valid=1 and ready=0.
  - Required: result_xreg_valid_o drops immediately, without waiting for a clock edge.
